// File: rtl/mem_alloc_pkg.sv
// Shared types and constants for the byte-serial memory allocator.
package mem_alloc_pkg;

    localparam int ADDR_W = 32;
    localparam int WORD_W = 32;

    localparam logic [1:0] IO_SEL = 2'b11;

    localparam logic [1:0] OFF_B = 2'd0;
    localparam logic [1:0] OFF_H = 2'd1;
    localparam logic [1:0] OFF_W = 2'd3;

    localparam int GNT_IF    = 0;
    localparam int GNT_LSB_R = 1;
    localparam int GNT_W     = 2;

    typedef enum logic [1:0] {
        IDLE,
        RD_IF,
        RD_LSB,
        WR
    } state_t;

    function automatic logic [7:0] get_byte(input logic [WORD_W-1:0] word,
                                            input logic [1:0]        idx);
        return word[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/mem_alloc_if.sv
// Request/response and RAM-port signals of the memory allocator.
import mem_alloc_pkg::*;

interface mem_alloc_if;

    logic              rdy_in;
    logic              clear_branch_in;

    logic              if_r_en_in;
    logic [ADDR_W-1:0] if_r_a_in;
    logic              alloc_to_if_gr_out;
    logic              alloc_to_if_en_out;
    logic [WORD_W-1:0] if_d_out;

    logic              lsb_to_alloc_r_en_in;
    logic [1:0]        lsb_r_offset_in;
    logic [ADDR_W-1:0] lsb_r_a_in;
    logic              alloc_to_lsb_r_gr_out;
    logic              alloc_to_lsb_r_en_out;
    logic [WORD_W-1:0] lsb_d_out;

    logic              lsb_to_alloc_w_en_in;
    logic [1:0]        lsb_w_offset_in;
    logic [ADDR_W-1:0] lsb_w_a_in;
    logic [WORD_W-1:0] lsb_d_in;
    logic              alloc_to_lsb_w_gr_out;
    logic              alloc_to_lsb_w_en_out;

    logic [7:0]        mem_din_in;
    logic [7:0]        mem_dout_out;
    logic [ADDR_W-1:0] mem_a_out;
    logic              mem_wr_out;
    logic              io_buffer_full_in;

    // Master is the surrounding system: requesters, RAM and IO status.
    modport master (
        output rdy_in, clear_branch_in,
        output if_r_en_in, if_r_a_in,
        input  alloc_to_if_gr_out, alloc_to_if_en_out, if_d_out,
        output lsb_to_alloc_r_en_in, lsb_r_offset_in, lsb_r_a_in,
        input  alloc_to_lsb_r_gr_out, alloc_to_lsb_r_en_out, lsb_d_out,
        output lsb_to_alloc_w_en_in, lsb_w_offset_in, lsb_w_a_in, lsb_d_in,
        input  alloc_to_lsb_w_gr_out, alloc_to_lsb_w_en_out,
        output mem_din_in, io_buffer_full_in,
        input  mem_dout_out, mem_a_out, mem_wr_out
    );

    modport slave (
        input  rdy_in, clear_branch_in,
        input  if_r_en_in, if_r_a_in,
        output alloc_to_if_gr_out, alloc_to_if_en_out, if_d_out,
        input  lsb_to_alloc_r_en_in, lsb_r_offset_in, lsb_r_a_in,
        output alloc_to_lsb_r_gr_out, alloc_to_lsb_r_en_out, lsb_d_out,
        input  lsb_to_alloc_w_en_in, lsb_w_offset_in, lsb_w_a_in, lsb_d_in,
        output alloc_to_lsb_w_gr_out, alloc_to_lsb_w_en_out,
        input  mem_din_in, io_buffer_full_in,
        output mem_dout_out, mem_a_out, mem_wr_out
    );

endinterface

// File: rtl/mem_alloc_arb.sv
// Fixed-priority request picker: write > LSB read > fetch.
import mem_alloc_pkg::*;

module mem_alloc_arb (
    input  logic              w_req,
    input  logic              lsb_r_req,
    input  logic              if_req,
    input  logic              block_reads,
    input  logic [ADDR_W-1:0] w_a,
    input  logic [ADDR_W-1:0] lsb_r_a,
    input  logic [ADDR_W-1:0] if_a,
    input  logic [1:0]        w_off,
    input  logic [1:0]        lsb_r_off,
    input  logic [WORD_W-1:0] w_d,
    output logic [2:0]        grant,
    output logic [ADDR_W-1:0] sel_a,
    output logic [1:0]        sel_off,
    output logic [WORD_W-1:0] sel_d
);

    // A flush blocks both reads but never a write.
    always_comb begin
        grant   = '0;
        sel_a   = '0;
        sel_off = OFF_B;
        sel_d   = '0;
        if (w_req) begin
            grant[GNT_W] = 1'b1;
            sel_a        = w_a;
            sel_off      = w_off;
            sel_d        = w_d;
        end else if (lsb_r_req && !block_reads) begin
            grant[GNT_LSB_R] = 1'b1;
            sel_a            = lsb_r_a;
            sel_off          = lsb_r_off;
        end else if (if_req && !block_reads) begin
            grant[GNT_IF] = 1'b1;
            sel_a         = if_a;
            sel_off       = OFF_W;
        end
    end

endmodule

// File: rtl/mem_alloc.sv
// Memory allocator: serves fetch, LSB read and LSB write requests over a
// byte-serial RAM port, assembling or splitting words one byte per cycle.
import mem_alloc_pkg::*;

module mem_alloc (
    input  logic       clk_in,
    input  logic       rst_n_in,
    mem_alloc_if.slave bus
);

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        off_q;
    logic [WORD_W-1:0] wdata_q;
    logic [WORD_W-1:0] rbuf;
    logic [2:0]        cnt;
    logic              paused;

    logic              if_gr_q, if_en_q;
    logic              lsb_r_gr_q, lsb_r_en_q;
    logic              w_gr_q, w_en_q;
    logic [WORD_W-1:0] if_d_q, lsb_d_q;
    logic [7:0]        dout_q;
    logic [ADDR_W-1:0] mem_a_q;
    logic              mem_wr_q;

    logic [2:0]        grant;
    logic [ADDR_W-1:0] sel_a;
    logic [1:0]        sel_off;
    logic [WORD_W-1:0] sel_d;
    logic [ADDR_W-1:0] cur_addr, nxt_addr;
    logic [WORD_W-1:0] rd_word;
    logic              io_stall_first, io_stall_cur;

    mem_alloc_arb u_arb (
        .w_req       (bus.lsb_to_alloc_w_en_in),
        .lsb_r_req   (bus.lsb_to_alloc_r_en_in),
        .if_req      (bus.if_r_en_in),
        .block_reads (bus.clear_branch_in),
        .w_a         (bus.lsb_w_a_in),
        .lsb_r_a     (bus.lsb_r_a_in),
        .if_a        (bus.if_r_a_in),
        .w_off       (bus.lsb_w_offset_in),
        .lsb_r_off   (bus.lsb_r_offset_in),
        .w_d         (bus.lsb_d_in),
        .grant       (grant),
        .sel_a       (sel_a),
        .sel_off     (sel_off),
        .sel_d       (sel_d)
    );

    assign cur_addr       = addr_q + {{(ADDR_W-3){1'b0}}, cnt};
    assign nxt_addr       = cur_addr + ADDR_W'(1);
    assign io_stall_first = (sel_a[17:16] == IO_SEL) && bus.io_buffer_full_in;
    assign io_stall_cur   = (cur_addr[17:16] == IO_SEL) && bus.io_buffer_full_in;

    // Word as it will look once the byte arriving this cycle is merged in.
    always_comb begin
        rd_word = rbuf;
        rd_word[{cnt[1:0], 3'b000} +: 8] = bus.mem_din_in;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state      <= IDLE;
            addr_q     <= '0;
            off_q      <= '0;
            wdata_q    <= '0;
            rbuf       <= '0;
            cnt        <= '0;
            paused     <= 1'b0;
            if_gr_q    <= 1'b0;
            if_en_q    <= 1'b0;
            lsb_r_gr_q <= 1'b0;
            lsb_r_en_q <= 1'b0;
            w_gr_q     <= 1'b0;
            w_en_q     <= 1'b0;
            if_d_q     <= '0;
            lsb_d_q    <= '0;
            dout_q     <= '0;
            mem_a_q    <= '0;
            mem_wr_q   <= 1'b0;
        end else begin
            if_gr_q    <= 1'b0;
            if_en_q    <= 1'b0;
            lsb_r_gr_q <= 1'b0;
            lsb_r_en_q <= 1'b0;
            w_gr_q     <= 1'b0;
            w_en_q     <= 1'b0;
            mem_wr_q   <= 1'b0;
            if (bus.rdy_in) begin
                case (state)
                    IDLE: begin
                        if (grant != 3'b000) begin
                            addr_q  <= sel_a;
                            off_q   <= sel_off;
                            wdata_q <= sel_d;
                            rbuf    <= '0;
                            mem_a_q <= sel_a;
                            cnt     <= '0;
                            if (grant[GNT_W]) begin
                                state  <= WR;
                                w_gr_q <= 1'b1;
                                if (!io_stall_first) begin
                                    dout_q   <= get_byte(sel_d, 2'd0);
                                    mem_wr_q <= 1'b1;
                                    cnt      <= 3'd1;
                                end
                            end else if (grant[GNT_LSB_R]) begin
                                state      <= RD_LSB;
                                lsb_r_gr_q <= 1'b1;
                            end else begin
                                state   <= RD_IF;
                                if_gr_q <= 1'b1;
                            end
                        end
                    end
                    RD_IF, RD_LSB: begin
                        if (bus.clear_branch_in) begin
                            state  <= IDLE;
                            cnt    <= '0;
                            paused <= 1'b0;
                        end else if (paused) begin
                            // The RAM may have moved on while frozen: refetch from byte 0.
                            paused  <= 1'b0;
                            cnt     <= '0;
                            mem_a_q <= addr_q;
                        end else begin
                            rbuf <= rd_word;
                            if (cnt[1:0] == off_q) begin
                                state <= IDLE;
                                cnt   <= '0;
                                if (state == RD_IF) begin
                                    if_d_q  <= rd_word;
                                    if_en_q <= 1'b1;
                                end else begin
                                    lsb_d_q    <= rd_word;
                                    lsb_r_en_q <= 1'b1;
                                end
                            end else begin
                                cnt     <= cnt + 3'd1;
                                mem_a_q <= nxt_addr;
                            end
                        end
                    end
                    WR: begin
                        if (cnt == ({1'b0, off_q} + 3'd1)) begin
                            state  <= IDLE;
                            cnt    <= '0;
                            w_en_q <= 1'b1;
                        end else if (!io_stall_cur) begin
                            mem_a_q  <= cur_addr;
                            dout_q   <= get_byte(wdata_q, cnt[1:0]);
                            mem_wr_q <= 1'b1;
                            cnt      <= cnt + 3'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end else if (state == RD_IF || state == RD_LSB) begin
                paused <= 1'b1;
            end
        end
    end

    assign bus.alloc_to_if_gr_out    = if_gr_q;
    assign bus.alloc_to_if_en_out    = if_en_q;
    assign bus.if_d_out              = if_d_q;
    assign bus.alloc_to_lsb_r_gr_out = lsb_r_gr_q;
    assign bus.alloc_to_lsb_r_en_out = lsb_r_en_q;
    assign bus.lsb_d_out             = lsb_d_q;
    assign bus.alloc_to_lsb_w_gr_out = w_gr_q;
    assign bus.alloc_to_lsb_w_en_out = w_en_q;
    assign bus.mem_dout_out          = dout_q;
    assign bus.mem_a_out             = mem_a_q;
    assign bus.mem_wr_out            = mem_wr_q;

endmodule
